// File: rtl/wb_cmd_pkg.sv
// Shared types and constants for the UART-command Wishbone sequencer.
// Opcodes, response codes, FSM states and status-word layout.
package wb_cmd_pkg;

  localparam int CMD_W = 34;

  typedef enum logic [1:0] {
    CMD_READ  = 2'b00,
    CMD_WRITE = 2'b01,
    CMD_ADDR  = 2'b10,
    CMD_STAT  = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    RSP_READ_OK  = 2'b00,
    RSP_WRITE_OK = 2'b01,
    RSP_ERR      = 2'b10,
    RSP_STAT     = 2'b11
  } rsp_code_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUS  = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  localparam int STAT_OVF  = 0;
  localparam int STAT_BERR = 1;
  localparam int STAT_TMO  = 2;

  function automatic logic [31:0] status_word(input logic [2:0] sticky, input logic [7:0] txn_cnt);
    return {16'h0000, txn_cnt, 5'b00000, sticky};
  endfunction

endpackage

// File: rtl/wb_cmd_buf.sv
// Single-entry command holding register; a push is accepted when empty or
// when the entry is popped in the same cycle, otherwise it is reported as dropped.
module wb_cmd_buf
  import wb_cmd_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [CMD_W-1:0] data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [CMD_W-1:0] data_o,
  output logic             drop_o
);

  logic             valid_q, valid_d;
  logic [CMD_W-1:0] data_q, data_d;
  logic             accept_s;

  // Next entry contents from push/pop.
  always_comb begin
    accept_s = push_i & (~valid_q | pop_i);
    valid_d  = valid_q;
    data_d   = data_q;
    if (accept_s) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (pop_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Entry registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= {CMD_W{1'b0}};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign drop_o  = push_i & ~accept_s;

endmodule

// File: rtl/wb_cmd_sequencer.sv
// Wishbone classic master driven by decoded UART commands; runs one bus
// cycle at a time with ack/err/timeout handling and returns a response word.
module wb_cmd_sequencer
  import wb_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_INC       = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [33:0] cmd_i,
  input  logic        cmd_valid_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [1:0]  rsp_code_o,
  output logic [31:0] rsp_data_o,
  output logic        overflow_o
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [31:0] dat_q, dat_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [1:0]  rsp_code_q, rsp_code_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic [2:0]  sticky_q, sticky_d;
  logic [7:0]  txn_q, txn_d;
  logic [15:0] tmo_q, tmo_d;

  logic             pop_s;
  logic             buf_valid_s;
  logic             buf_drop_s;
  logic [CMD_W-1:0] buf_data_s;
  opcode_e          op_s;
  logic [31:0]      payload_s;

  assign pop_s     = (state_q == ST_IDLE) & buf_valid_s;
  assign op_s      = opcode_e'(buf_data_s[33:32]);
  assign payload_s = buf_data_s[31:0];

  wb_cmd_buf u_buf (
    .clk     (clk),
    .rst     (rst),
    .push_i  (cmd_valid_i),
    .data_i  (cmd_i),
    .pop_i   (pop_s),
    .valid_o (buf_valid_s),
    .data_o  (buf_data_s),
    .drop_o  (buf_drop_s)
  );

  // Sequencer next-state, bus and response logic.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    dat_d       = dat_q;
    rsp_valid_d = rsp_valid_q;
    rsp_code_d  = rsp_code_q;
    rsp_data_d  = rsp_data_q;
    sticky_d    = sticky_q;
    txn_d       = txn_q;
    tmo_d       = tmo_q;
    case (state_q)
      ST_IDLE: begin
        if (pop_s) begin
          case (op_s)
            CMD_ADDR: addr_d = payload_s;
            CMD_STAT: begin
              rsp_valid_d = 1'b1;
              rsp_code_d  = RSP_STAT;
              rsp_data_d  = status_word(sticky_q, txn_q);
              sticky_d    = 3'b000;
              state_d     = ST_RESP;
            end
            default: begin
              cyc_d   = 1'b1;
              we_d    = (op_s == CMD_WRITE);
              dat_d   = (op_s == CMD_WRITE) ? payload_s : 32'h0000_0000;
              tmo_d   = 16'd0;
              state_d = ST_BUS;
            end
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUS: begin
        if (wb_err_i || wb_ack_i || (tmo_q == TMO_LAST)) begin
          cyc_d       = 1'b0;
          we_d        = 1'b0;
          dat_d       = 32'h0000_0000;
          rsp_valid_d = 1'b1;
          txn_d       = txn_q + 8'd1;
          state_d     = ST_RESP;
          // err outranks ack; neither means the cycle budget ran out.
          if (wb_err_i) begin
            rsp_code_d          = RSP_ERR;
            rsp_data_d          = 32'h0000_0000;
            sticky_d[STAT_BERR] = 1'b1;
          end else if (wb_ack_i) begin
            rsp_code_d = we_q ? RSP_WRITE_OK : RSP_READ_OK;
            rsp_data_d = we_q ? addr_q : wb_dat_i;
            if (AUTO_INC) begin
              addr_d = addr_q + 32'd4;
            end else begin
              addr_d = addr_q;
            end
          end else begin
            rsp_code_d         = RSP_ERR;
            rsp_data_d         = 32'h0000_0000;
            sticky_d[STAT_TMO] = 1'b1;
          end
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A drop in the same cycle as a status read is a new event and survives the clear.
    if (buf_drop_s) begin
      sticky_d[STAT_OVF] = 1'b1;
    end else begin
      sticky_d[STAT_OVF] = sticky_d[STAT_OVF];
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= 32'h0000_0000;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      dat_q       <= 32'h0000_0000;
      rsp_valid_q <= 1'b0;
      rsp_code_q  <= 2'b00;
      rsp_data_q  <= 32'h0000_0000;
      sticky_q    <= 3'b000;
      txn_q       <= 8'd0;
      tmo_q       <= 16'd0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_code_q  <= rsp_code_d;
      rsp_data_q  <= rsp_data_d;
      sticky_q    <= sticky_d;
      txn_q       <= txn_d;
      tmo_q       <= tmo_d;
    end
  end

  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = cyc_q;
  assign wb_we_o     = we_q;
  assign wb_adr_o    = addr_q;
  assign wb_dat_o    = dat_q;
  assign wb_sel_o    = cyc_q ? 4'hF : 4'h0;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_code_o  = rsp_code_q;
  assign rsp_data_o  = rsp_data_q;
  assign overflow_o  = sticky_q[STAT_OVF];

endmodule

// File: tb/tb_wb_cmd_sequencer.sv
// Directed bench for wb_cmd_sequencer: hand-computed expectations checked
// with immediate assertions, one step after each rising edge.
module tb_wb_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [33:0] cmd_i = 34'd0;
  logic        cmd_valid_i = 1'b0;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i = 32'd0;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [1:0]  rsp_code_o;
  logic [31:0] rsp_data_o;
  logic        overflow_o;

  int vectors = 0;
  int miscompares = 0;

  wb_cmd_sequencer #(.TIMEOUT_CYCLES(8), .AUTO_INC(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_i       (cmd_i),
    .cmd_valid_i (cmd_valid_i),
    .wb_cyc_o    (wb_cyc_o),
    .wb_stb_o    (wb_stb_o),
    .wb_we_o     (wb_we_o),
    .wb_adr_o    (wb_adr_o),
    .wb_dat_o    (wb_dat_o),
    .wb_sel_o    (wb_sel_o),
    .wb_dat_i    (wb_dat_i),
    .wb_ack_i    (wb_ack_i),
    .wb_err_i    (wb_err_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_code_o  (rsp_code_o),
    .rsp_data_o  (rsp_data_o),
    .overflow_o  (overflow_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] payload);
    cmd_i = {op, payload};
    cmd_valid_i = 1'b1;
    tick();
    cmd_valid_i = 1'b0;
  endtask

  task automatic accept();
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
  endtask

  task automatic chk_rsp(input string tag, input logic [1:0] code, input logic [31:0] data);
    chk({tag, "_valid"}, {31'd0, rsp_valid_o}, 32'd1);
    chk({tag, "_code"}, {30'd0, rsp_code_o}, {30'd0, code});
    chk({tag, "_data"}, rsp_data_o, data);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
    chk("rst_stb", {31'd0, wb_stb_o}, 32'd0);
    chk("rst_adr", wb_adr_o, 32'd0);
    chk("rst_sel", {28'd0, wb_sel_o}, 32'd0);
    chk("rst_rspv", {31'd0, rsp_valid_o}, 32'd0);
    chk("rst_ovf", {31'd0, overflow_o}, 32'd0);
    tick();
    rst = 1'b1;
    tick();

    // A 0x1000 then W 0xCAFEBABE acked after two cycles
    send(2'b10, 32'h0000_1000);
    tick();
    chk("a_adr", wb_adr_o, 32'h0000_1000);
    chk("a_cyc", {31'd0, wb_cyc_o}, 32'd0);
    chk("a_rspv", {31'd0, rsp_valid_o}, 32'd0);
    send(2'b01, 32'hCAFE_BABE);
    tick();
    chk("w_cyc", {31'd0, wb_cyc_o}, 32'd1);
    chk("w_stb", {31'd0, wb_stb_o}, 32'd1);
    chk("w_we", {31'd0, wb_we_o}, 32'd1);
    chk("w_adr", wb_adr_o, 32'h0000_1000);
    chk("w_dat", wb_dat_o, 32'hCAFE_BABE);
    chk("w_sel", {28'd0, wb_sel_o}, 32'hF);
    tick();
    chk("w_cyc_hold", {31'd0, wb_cyc_o}, 32'd1);
    wb_ack_i = 1'b1;
    tick();
    wb_ack_i = 1'b0;
    chk("w_cyc_done", {31'd0, wb_cyc_o}, 32'd0);
    chk_rsp("w_rsp", 2'b01, 32'h0000_1000);
    chk("w_adr_inc", wb_adr_o, 32'h0000_1004);
    accept();
    chk("w_rspv_low", {31'd0, rsp_valid_o}, 32'd0);

    // R returning 0x12345678, response held for 5 cycles
    send(2'b00, 32'h0000_0000);
    tick();
    chk("r_cyc", {31'd0, wb_cyc_o}, 32'd1);
    chk("r_we", {31'd0, wb_we_o}, 32'd0);
    chk("r_dat0", wb_dat_o, 32'd0);
    chk("r_adr", wb_adr_o, 32'h0000_1004);
    wb_dat_i = 32'h1234_5678;
    wb_ack_i = 1'b1;
    tick();
    wb_ack_i = 1'b0;
    wb_dat_i = 32'd0;
    chk_rsp("r_rsp", 2'b00, 32'h1234_5678);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_rsp("r_hold", 2'b00, 32'h1234_5678);
    end
    chk("r_adr_inc", wb_adr_o, 32'h0000_1008);
    accept();

    // R with no termination: abort on the 8th edge in BUS
    send(2'b00, 32'h0000_0000);
    tick();
    chk("t_cyc_start", {31'd0, wb_cyc_o}, 32'd1);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("t_cyc_wait", {31'd0, wb_cyc_o}, 32'd1);
    end
    tick();
    chk("t_cyc_drop", {31'd0, wb_cyc_o}, 32'd0);
    chk_rsp("t_rsp", 2'b10, 32'd0);
    chk("t_adr_same", wb_adr_o, 32'h0000_1008);
    accept();
    // Three transactions so far (W, R, R) and the timeout bit
    send(2'b11, 32'd0);
    tick();
    chk_rsp("s1_rsp", 2'b11, 32'h0000_0304);
    accept();
    send(2'b11, 32'd0);
    tick();
    chk_rsp("s2_rsp", 2'b11, 32'h0000_0300);
    accept();

    // err and ack together: error wins, no increment
    send(2'b01, 32'h55AA_55AA);
    tick();
    chk("e_cyc", {31'd0, wb_cyc_o}, 32'd1);
    wb_err_i = 1'b1;
    wb_ack_i = 1'b1;
    tick();
    wb_err_i = 1'b0;
    wb_ack_i = 1'b0;
    chk_rsp("e_rsp", 2'b10, 32'd0);
    chk("e_adr_same", wb_adr_o, 32'h0000_1008);
    accept();
    send(2'b11, 32'd0);
    tick();
    chk_rsp("s3_rsp", 2'b11, 32'h0000_0402);
    accept();

    // Three pulses while a response is pending: first kept, two dropped
    send(2'b11, 32'd0);
    tick();
    chk_rsp("s4_rsp", 2'b11, 32'h0000_0400);
    cmd_i = {2'b10, 32'h0000_2000};
    cmd_valid_i = 1'b1;
    tick();
    cmd_i = {2'b10, 32'h0000_3000};
    tick();
    cmd_i = {2'b01, 32'hDEAD_BEEF};
    tick();
    cmd_valid_i = 1'b0;
    chk("o_ovf", {31'd0, overflow_o}, 32'd1);
    chk_rsp("o_rsp_held", 2'b11, 32'h0000_0400);
    accept();
    chk("o_rspv_low", {31'd0, rsp_valid_o}, 32'd0);
    chk("o_adr_before", wb_adr_o, 32'h0000_1008);
    tick();
    chk("o_adr_after", wb_adr_o, 32'h0000_2000);
    tick();
    tick();
    chk("o_adr_final", wb_adr_o, 32'h0000_2000);
    chk("o_cyc_idle", {31'd0, wb_cyc_o}, 32'd0);
    chk("o_rspv_idle", {31'd0, rsp_valid_o}, 32'd0);

    // Reset asserted mid-BUS
    send(2'b00, 32'd0);
    tick();
    chk("x_cyc", {31'd0, wb_cyc_o}, 32'd1);
    tick();
    rst = 1'b0;
    #1;
    chk("x_cyc_async", {31'd0, wb_cyc_o}, 32'd0);
    chk("x_stb_async", {31'd0, wb_stb_o}, 32'd0);
    chk("x_adr", wb_adr_o, 32'd0);
    chk("x_sel", {28'd0, wb_sel_o}, 32'd0);
    chk("x_ovf", {31'd0, overflow_o}, 32'd0);
    chk("x_rspd", rsp_data_o, 32'd0);
    tick();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("x_no_rsp", {31'd0, rsp_valid_o}, 32'd0);
      chk("x_no_cyc", {31'd0, wb_cyc_o}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
